// File: rtl/data_cal_seq.sv
// data_cal_seq: FIFO-buffered word sequencer driving d/sel into data_cal.
// Define SEQ_WORD_CNT_EN to add the word_cnt completed-word counter output.
module data_cal_seq #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic [2:0]  in_mask,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] d_out,
    output logic [1:0]  sel_out,
    output logic        busy,
`ifdef SEQ_WORD_CNT_EN
    output logic [15:0] word_cnt,
`endif
    output logic        done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CALC = 2'd2;

    logic [1:0]    state;
    logic [18:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [2:0]    mask_r;
    logic [2:0]    mask_rest;
    logic [18:0]   head;
    logic          empty;
    logic          push;
    logic          pop;
    logic          last;

    function automatic logic [1:0] low_sel(input logic [2:0] m);
        if (m[0])      return 2'd1;
        else if (m[1]) return 2'd2;
        else if (m[2]) return 2'd3;
        else           return 2'd0;
    endfunction

    assign head      = mem[rd_ptr];
    assign empty     = (count == '0);
    assign in_ready  = (count != FULL_CNT);
    assign push      = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign mask_rest = mask_r & (mask_r - 3'd1);
    // mask_r holds the ops not yet issued, so an empty mask ends the word
    assign last      = (state != IDLE) && (mask_r == 3'b000);
    assign pop       = !empty && ((state == IDLE) || last);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_mask, in_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            d_out   <= '0;
            sel_out <= '0;
            done    <= 1'b0;
            mask_r  <= '0;
        end else if (pop) begin
            state   <= LOAD;
            d_out   <= head[15:0];
            mask_r  <= head[18:16];
            sel_out <= 2'd0;
            done    <= (head[18:16] == 3'b000);
        end else if (state != IDLE && mask_r != 3'b000) begin
            state   <= CALC;
            sel_out <= low_sel(mask_r);
            mask_r  <= mask_rest;
            done    <= (mask_rest == 3'b000);
        end else begin
            state   <= IDLE;
            sel_out <= 2'd0;
            done    <= 1'b0;
        end
    end

`ifdef SEQ_WORD_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      word_cnt <= '0;
        else if (done) word_cnt <= word_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_data_cal_seq.sv
// tb_data_cal_seq: directed scenarios for the data_cal_seq word sequencer.
// Define SEQ_WORD_CNT_EN to include the word counter scenario.
`timescale 1ns/1ps
module tb_data_cal_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data = '0;
    logic [2:0]  in_mask = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] d_out;
    logic [1:0]  sel_out;
    logic        busy;
    logic        done;
`ifdef SEQ_WORD_CNT_EN
    logic [15:0] word_cnt;
`endif

    int checks = 0;
    int errors = 0;

    data_cal_seq #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_mask  (in_mask),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d_out    (d_out),
        .sel_out  (sel_out),
        .busy     (busy),
`ifdef SEQ_WORD_CNT_EN
        .word_cnt (word_cnt),
`endif
        .done     (done)
    );

    always #5 clk = ~clk;

    // Drive one word for exactly one accepting edge; returns at the next negedge.
    task automatic push_one(input logic [15:0] d, input logic [2:0] m);
        @(negedge clk);
        in_data  = d;
        in_mask  = m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++;
        if ({d_out, sel_out, done, busy} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got d=%h sel=%0d done=%b busy=%b want all 0",
                     d_out, sel_out, done, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_full_mask();
        logic [1:0] es [4];
        logic       ed [4];
        es = '{2'd0, 2'd1, 2'd2, 2'd3};
        ed = '{1'b0, 1'b0, 1'b0, 1'b1};
        push_one(16'h4321, 3'b111);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (d_out !== 16'h4321 || sel_out !== es[i] || done !== ed[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL full_mask_cyc%0d: got d=%h sel=%0d done=%b busy=%b want d=4321 sel=%0d done=%b busy=1",
                         i, d_out, sel_out, done, busy, es[i], ed[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sel_out !== 2'd0 || done !== 1'b0 || d_out !== 16'h4321) begin
            errors++;
            $display("FAIL full_mask_idle: got d=%h sel=%0d done=%b busy=%b want d=4321 sel=0 done=0 busy=0",
                     d_out, sel_out, done, busy);
        end
    endtask

    task automatic test_skip_mask();
        logic [1:0] es [3];
        logic       ed [3];
        es = '{2'd0, 2'd1, 2'd3};
        ed = '{1'b0, 1'b0, 1'b1};
        push_one(16'hA5F0, 3'b101);
        in_mask = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (d_out !== 16'hA5F0 || sel_out !== es[i] || done !== ed[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL skip_mask_cyc%0d: got d=%h sel=%0d done=%b busy=%b want d=a5f0 sel=%0d done=%b busy=1",
                         i, d_out, sel_out, done, busy, es[i], ed[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sel_out !== 2'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL skip_mask_idle: got sel=%0d done=%b busy=%b want 0 0 0",
                     sel_out, done, busy);
        end
    endtask

    task automatic test_zero_mask();
        push_one(16'h0F0F, 3'b000);
        @(negedge clk);
        checks++;
        if (d_out !== 16'h0F0F || sel_out !== 2'd0 || done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_mask_load: got d=%h sel=%0d done=%b busy=%b want d=0f0f sel=0 done=1 busy=1",
                     d_out, sel_out, done, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sel_out !== 2'd0) begin
            errors++;
            $display("FAIL zero_mask_idle: got sel=%0d done=%b busy=%b want 0 0 0",
                     sel_out, done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] wd [6];
        logic [2:0]  wm [6];
        logic [15:0] qd [$];
        logic [1:0]  qs [$];
        logic        qn [$];
        logic        saw_full;
        wd = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005, 16'h6006};
        wm = '{3'b111, 3'b001, 3'b000, 3'b110, 3'b100, 3'b011};
        for (int w = 0; w < 6; w++) begin
            logic [2:0] m;
            m = wm[w];
            qd.push_back(wd[w]); qs.push_back(2'd0); qn.push_back(m == 3'b000);
            for (int b = 0; b < 3; b++) begin
                if (m[b]) begin
                    m[b] = 1'b0;
                    qd.push_back(wd[w]);
                    qs.push_back(2'(b + 1));
                    qn.push_back(m == 3'b000);
                end
            end
        end
        saw_full = 1'b0;
        fork
            begin
                int i;
                int guard;
                logic rdy;
                i = 0;
                guard = 0;
                in_data  = wd[0];
                in_mask  = wm[0];
                in_valid = 1'b1;
                while (i < 6 && guard < 100) begin
                    rdy = in_ready;
                    @(negedge clk);
                    guard++;
                    if (rdy) begin
                        i++;
                        if (i < 6) begin
                            in_data = wd[i];
                            in_mask = wm[i];
                        end else begin
                            in_valid = 1'b0;
                        end
                    end else begin
                        saw_full = 1'b1;
                    end
                end
                in_valid = 1'b0;
                checks++;
                if (i !== 6) begin
                    errors++;
                    $display("FAIL b2b_accept: got %0d words accepted want 6", i);
                end
            end
            begin
                int n;
                n = 0;
                while (busy !== 1'b1 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_start: got busy=%b want 1 within 20 cycles", busy);
                end
                for (int k = 0; k < qs.size(); k++) begin
                    checks++;
                    if (d_out !== qd[k] || sel_out !== qs[k] || done !== qn[k] || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_step%0d: got d=%h sel=%0d done=%b busy=%b want d=%h sel=%0d done=%b busy=1",
                                 k, d_out, sel_out, done, busy, qd[k], qs[k], qn[k]);
                    end
                    @(negedge clk);
                end
                checks++;
                if (busy !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_end: got busy=%b in_ready=%b want 0 1", busy, in_ready);
                end
            end
        join
        checks++;
        if (saw_full !== 1'b1) begin
            errors++;
            $display("FAIL b2b_full: got in_ready never low want low at count 4");
        end
    endtask

    task automatic test_reset_mid_word();
        logic [1:0] es [2];
        logic       ed [2];
        es = '{2'd0, 2'd2};
        ed = '{1'b0, 1'b1};
        push_one(16'hDEAD, 3'b111);
        push_one(16'hBEEF, 3'b111);
        checks++;
        if (sel_out !== 2'd1 || d_out !== 16'hDEAD) begin
            errors++;
            $display("FAIL rst_mid_pre: got d=%h sel=%0d want d=dead sel=1", d_out, sel_out);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({d_out, sel_out, done, busy} !== 20'h0) begin
            errors++;
            $display("FAIL rst_mid_async: got d=%h sel=%0d done=%b busy=%b want all 0",
                     d_out, sel_out, done, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid_empty%0d: got busy=%b done=%b in_ready=%b want 0 0 1",
                         i, busy, done, in_ready);
            end
        end
        push_one(16'h0BAD, 3'b010);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (d_out !== 16'h0BAD || sel_out !== es[i] || done !== ed[i]) begin
                errors++;
                $display("FAIL rst_mid_after%0d: got d=%h sel=%0d done=%b want d=0bad sel=%0d done=%b",
                         i, d_out, sel_out, done, es[i], ed[i]);
            end
        end
        @(negedge clk);
    endtask

`ifdef SEQ_WORD_CNT_EN
    task automatic test_word_cnt();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (word_cnt !== 16'd0) begin
            errors++;
            $display("FAIL cnt_reset: got %0d want 0", word_cnt);
        end
        push_one(16'h0001, 3'b001);
        push_one(16'h0002, 3'b000);
        push_one(16'h0003, 3'b100);
        repeat (4) @(negedge clk);
        checks++;
        if (word_cnt !== 16'd3) begin
            errors++;
            $display("FAIL cnt_three: got %0d want 3", word_cnt);
        end
        force dut.word_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.word_cnt;
        push_one(16'h0004, 3'b000);
        repeat (2) @(negedge clk);
        checks++;
        if (word_cnt !== 16'd0) begin
            errors++;
            $display("FAIL cnt_wrap: got %h want 0000", word_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_mask();
        test_skip_mask();
        test_zero_mask();
        test_back_to_back();
        test_reset_mid_word();
`ifdef SEQ_WORD_CNT_EN
        test_word_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
